ex_operand_stage: RTL and testbench

ID/EX pipeline stage that feeds the alu. Registers one decoded instruction with a valid/ready handshake and decodes opcode/funct fields into the 4-bit alu_control. Resolves RAW hazards by forwarding from EX/MEM and WB, and inserts a one-cycle load-use bubble. Presents alu a, b and alu_control plus sideband control for the MEM stage.

---
 rtl/rv_pkg.sv | 28 ++
 rtl/alu_ctrl_decode.sv | 84 ++++++++
 rtl/ex_operand_stage.sv | 198 +++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 decode constants for the ID/EX operand stage and its ALU control decoder.
// Latency: n/a. This file holds constants only.
// Backpressure: n/a.
// Contents: XLEN and REGA defaults, major opcodes, funct3 selectors and 4-bit ALU operation codes.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int REGA = 5;

    // Major opcodes (instr[6:0]) handled by the stage
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // funct3 selectors for the supported ALU operations
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;

    // ALU operation codes presented on alu_control
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0010;
    localparam logic [3:0] ALU_PASSB = 4'b0011;
    localparam logic [3:0] ALU_NOP   = 4'b1111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps opcode/funct3/funct7b5 onto the ALU op, operand-source selects and MEM/WB enables.
// Latency: purely combinational (0 cycles).
// Backpressure: none; output follows input.
// Ports: opcode/funct3/funct7b5 in; alu_control, use_imm, use_rs1, use_rs2,
//        reg_write, mem_read, mem_write and illegal out.
module alu_ctrl_decode (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control,
    output logic       use_imm,
    output logic       use_rs1,
    output logic       use_rs2,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       illegal
);
    import rv_pkg::*;

    always_comb begin
        // Anything not matched below is reported illegal with every enable off
        alu_control = ALU_NOP;
        use_imm     = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        illegal     = 1'b1;

        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD || funct3 == F3_XOR) begin
                    // funct7b5 selects sub only for the add/sub funct3
                    if (funct3 == F3_XOR) begin
                        alu_control = ALU_XOR;
                    end else begin
                        alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
                    end
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    reg_write = 1'b1;
                    illegal   = 1'b0;
                end
            end
            OP_IMM: begin
                if (funct3 == F3_ADD || funct3 == F3_XOR) begin
                    alu_control = (funct3 == F3_XOR) ? ALU_XOR : ALU_ADD;
                    use_imm     = 1'b1;
                    use_rs1     = 1'b1;
                    reg_write   = 1'b1;
                    illegal     = 1'b0;
                end
            end
            OP_LUI: begin
                alu_control = ALU_PASSB;
                use_imm     = 1'b1;
                reg_write   = 1'b1;
                illegal     = 1'b0;
            end
            OP_LOAD: begin
                alu_control = ALU_ADD;
                use_imm     = 1'b1;
                use_rs1     = 1'b1;
                reg_write   = 1'b1;
                mem_read    = 1'b1;
                illegal     = 1'b0;
            end
            OP_STORE: begin
                // rs2 is not an ALU operand here, but it is read as store data
                alu_control = ALU_ADD;
                use_imm     = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                mem_write   = 1'b1;
                illegal     = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU: decode, EX/MEM and WB forwarding, load-use bubble.
// Latency: 1 cycle from accept to out_valid; with out_ready held high it sustains full throughput.
// Backpressure: in_ready = (empty or draining) and no load-use hazard. flush forces in_ready high and kills the entry.
// Ports: clk/rst (sync, active-high), flush; in_* decoded instruction with valid/ready;
//        exm_* and wb_* forwarding sources; out_valid/out_ready with alu_a, alu_b,
//        alu_control, out_rd, MEM/WB enables, out_store_data and out_illegal.
module ex_operand_stage #(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int REGA = rv_pkg::REGA
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [REGA-1:0] in_rs1_addr,
    input  logic [REGA-1:0] in_rs2_addr,
    input  logic [REGA-1:0] in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            exm_wr_en,
    input  logic [REGA-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_wr_en,
    input  logic [REGA-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic [REGA-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_illegal
);
    import rv_pkg::*;

    // One held instruction, kept in decoded form
    typedef struct packed {
        logic [3:0]      alu_control;
        logic            use_imm;
        logic            zero_a;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
        logic [REGA-1:0] rs1_addr;
        logic [REGA-1:0] rs2_addr;
        logic [REGA-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } entry_t;

    entry_t          ent;
    entry_t          incoming;
    logic            occupied;
    logic            load_use;
    logic            accept;
    logic            drain;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    logic [3:0]      dec_alu_control;
    logic            dec_use_imm;
    logic            dec_use_rs1;
    logic            dec_use_rs2;
    logic            dec_reg_write;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_illegal;

    // Decode the incoming instruction. Its source-use flags drive the hazard
    // check, and the remaining fields are captured into the entry.
    alu_ctrl_decode u_dec (
        .opcode      (in_opcode),
        .funct3      (in_funct3),
        .funct7b5    (in_funct7b5),
        .alu_control (dec_alu_control),
        .use_imm     (dec_use_imm),
        .use_rs1     (dec_use_rs1),
        .use_rs2     (dec_use_rs2),
        .reg_write   (dec_reg_write),
        .mem_read    (dec_mem_read),
        .mem_write   (dec_mem_write),
        .illegal     (dec_illegal)
    );

    // EX/MEM beats WB because it is the younger producer. x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [REGA-1:0] src,
        input logic [XLEN-1:0] stored,
        input logic            ex_we,
        input logic [REGA-1:0] ex_dst,
        input logic [XLEN-1:0] ex_val,
        input logic            w_we,
        input logic [REGA-1:0] w_dst,
        input logic [XLEN-1:0] w_val
    );
        logic [XLEN-1:0] v;
        v = stored;
        if (src != '0) begin
            if (ex_we && ex_dst == src) begin
                v = ex_val;
            end else if (w_we && w_dst == src) begin
                v = w_val;
            end
        end
        return v;
    endfunction

    always_comb begin
        fwd_rs1 = fwd_operand(ent.rs1_addr, ent.rs1_data, exm_wr_en, exm_rd, exm_result,
                              wb_wr_en, wb_rd, wb_data);
        fwd_rs2 = fwd_operand(ent.rs2_addr, ent.rs2_data, exm_wr_en, exm_rd, exm_result,
                              wb_wr_en, wb_rd, wb_data);
    end

    // A held load cannot forward its data yet, so a dependent instruction
    // waits. Once the load leaves, the stage sits empty for one cycle.
    assign load_use = occupied && ent.mem_read && (ent.rd != '0) && in_valid &&
                      ((dec_use_rs1 && in_rs1_addr == ent.rd) ||
                       (dec_use_rs2 && in_rs2_addr == ent.rd));

    // During flush, ready is forced high so upstream drops its instruction.
    assign in_ready = flush || ((!occupied || out_ready) && !load_use);
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = occupied && out_ready;

    always_comb begin
        incoming             = '0;
        incoming.alu_control = dec_alu_control;
        incoming.use_imm     = dec_use_imm;
        incoming.zero_a      = (in_opcode == OP_LUI);
        incoming.reg_write   = dec_reg_write && (in_rd_addr != '0);
        incoming.mem_read    = dec_mem_read;
        incoming.mem_write   = dec_mem_write;
        incoming.illegal     = dec_illegal;
        incoming.rs1_addr    = in_rs1_addr;
        incoming.rs2_addr    = in_rs2_addr;
        incoming.rd          = in_rd_addr;
        incoming.rs1_data    = in_rs1_data;
        incoming.rs2_data    = in_rs2_data;
        incoming.imm         = in_imm;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupied <= 1'b0;
            ent      <= '0;
        end else if (accept) begin
            occupied <= 1'b1;
            ent      <= incoming;
        end else if (drain) begin
            occupied <= 1'b0;
            ent      <= '0;
        end else if (occupied) begin
            // Stalled: latch the forwarded values now, so a producer that
            // retires during the stall is not lost.
            ent.rs1_data <= fwd_rs1;
            ent.rs2_data <= fwd_rs2;
        end
    end

    assign out_valid = occupied;

    // Every output is held at zero while the stage is empty.
    always_comb begin
        alu_a          = '0;
        alu_b          = '0;
        alu_control    = '0;
        out_rd         = '0;
        out_reg_write  = 1'b0;
        out_mem_read   = 1'b0;
        out_mem_write  = 1'b0;
        out_store_data = '0;
        out_illegal    = 1'b0;
        if (occupied) begin
            alu_a          = ent.zero_a ? '0 : fwd_rs1;
            alu_b          = ent.use_imm ? ent.imm : fwd_rs2;
            alu_control    = ent.alu_control;
            out_rd         = ent.rd;
            out_reg_write  = ent.reg_write;
            out_mem_read   = ent.mem_read;
            out_mem_write  = ent.mem_write;
            out_store_data = fwd_rs2;
            out_illegal    = ent.illegal;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: a table of directed cycles, then random traffic against a model.
// Latency: n/a (testbench).
// Backpressure: out_ready driven from the table or at random.
`timescale 1ns/1ps
module tb_ex_operand_stage;

    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] OPLU = 7'b0110111;
    localparam logic [6:0] OPLD = 7'b0000011;
    localparam logic [6:0] OPST = 7'b0100011;
    localparam logic [6:0] OPBR = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_funct7b5;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, exm_rd, wb_rd, out_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, exm_result, wb_data;
    logic        exm_wr_en, wb_wr_en, out_valid, out_ready;
    logic [31:0] alu_a, alu_b, out_store_data;
    logic [3:0]  alu_control;
    logic        out_reg_write, out_mem_read, out_mem_write, out_illegal;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_store_data(out_store_data), .out_illegal(out_illegal)
    );

    typedef struct {
        logic        rst, flush, in_valid, out_ready;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        exm_we;
        logic [4:0]  exm_rd;
        logic [31:0] exm_res;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_dat;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        ev, er;
        logic [31:0] ea, eb;
        logic [3:0]  ec;
        logic        eill, erw;
    } vec_t;

    typedef enum {K_R, K_I, K_LUI, K_LD, K_ST, K_BAD} kind_e;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.flush = 0; s.in_valid = 0; s.out_ready = 1;
        s.op = 0; s.f3 = 0; s.f7 = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        s.d1 = 0; s.d2 = 0; s.imm = 0;
        s.exm_we = 0; s.exm_rd = 0; s.exm_res = 0;
        s.wb_we = 0; s.wb_rd = 0; s.wb_dat = 0;
        return s;
    endfunction

    function automatic stim_t ins(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        stim_t s;
        s = idle();
        s.in_valid = 1; s.op = op; s.f3 = f3; s.f7 = f7;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.d1 = d1; s.d2 = d2; s.imm = imm;
        return s;
    endfunction

    task automatic add_vec(input stim_t s, input logic ev, input logic er,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] ec,
                           input logic eill, input logic erw);
        vec_t v;
        v.s = s; v.ev = ev; v.er = er; v.ea = ea; v.eb = eb; v.ec = ec; v.eill = eill; v.erw = erw;
        vecs.push_back(v);
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst; flush = s.flush; in_valid = s.in_valid; out_ready = s.out_ready;
        in_opcode = s.op; in_funct3 = s.f3; in_funct7b5 = s.f7;
        in_rs1_addr = s.rs1; in_rs2_addr = s.rs2; in_rd_addr = s.rd;
        in_rs1_data = s.d1; in_rs2_data = s.d2; in_imm = s.imm;
        exm_wr_en = s.exm_we; exm_rd = s.exm_rd; exm_result = s.exm_res;
        wb_wr_en = s.wb_we; wb_rd = s.wb_rd; wb_data = s.wb_dat;
    endtask

    // ---- reference model: instruction classes and their meaning ----
    function automatic kind_e kind_of(input logic [6:0] op, input logic [2:0] f3);
        if (op == OPR && (f3 == 3'd0 || f3 == 3'd4)) return K_R;
        if (op == OPI && (f3 == 3'd0 || f3 == 3'd4)) return K_I;
        if (op == OPLU) return K_LUI;
        if (op == OPLD) return K_LD;
        if (op == OPST) return K_ST;
        return K_BAD;
    endfunction

    function automatic logic [3:0] code_of(input kind_e k, input logic [2:0] f3, input logic f7);
        case (k)
            K_R:     return (f3 == 3'd4) ? 4'd2 : (f7 ? 4'd1 : 4'd0);
            K_I:     return (f3 == 3'd4) ? 4'd2 : 4'd0;
            K_LUI:   return 4'd3;
            K_BAD:   return 4'hF;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] stored, input stim_t s);
        if (src != 0 && s.exm_we && s.exm_rd == src) return s.exm_res;
        if (src != 0 && s.wb_we && s.wb_rd == src) return s.wb_dat;
        return stored;
    endfunction

    // model state: the raw instruction the stage should be holding
    logic        m_vld;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;

    initial begin
        stim_t t;
        vec_t  v;

        // ---- directed table (expected values checked mid-cycle, before the capturing edge) ----
        add_vec(idle(),                                   0,1, 32'h0,     32'h0,        4'h0,0,0); // reset state
        add_vec(ins(OPR,3'd0,1'b0,5,6,1,7,3,0),           0,1, 32'h0,     32'h0,        4'h0,0,0);
        add_vec(ins(OPR,3'd0,1'b1,5,6,2,10,4,0),          1,1, 32'd7,     32'd3,        4'h0,0,1); // add
        add_vec(ins(OPI,3'd4,1'b0,2,0,3,32'hF0,0,32'h0F), 1,1, 32'd10,    32'd4,        4'h1,0,1); // sub
        add_vec(ins(OPR,3'd0,1'b0,5,0,3,1,0,0),           1,1, 32'hF0,    32'h0F,       4'h2,0,1); // xori
        t = idle(); t.exm_we = 1; t.exm_rd = 5; t.exm_res = 32'hAAAA;
        t.wb_we = 1; t.wb_rd = 5; t.wb_dat = 32'hBBBB;
        add_vec(t,                                        1,1, 32'hAAAA,  32'h0,        4'h0,0,1); // EX/MEM wins
        add_vec(ins(OPR,3'd0,1'b0,0,0,4,0,0,0),           0,1, 32'h0,     32'h0,        4'h0,0,0);
        t = idle(); t.exm_we = 1; t.exm_rd = 0; t.exm_res = 32'h1234;
        add_vec(t,                                        1,1, 32'h0,     32'h0,        4'h0,0,1); // x0 not forwarded
        add_vec(ins(OPR,3'd0,1'b0,1,2,0,5,6,0),           0,1, 32'h0,     32'h0,        4'h0,0,0);
        add_vec(idle(),                                   1,1, 32'd5,     32'd6,        4'h0,0,0); // rd=0 -> no write
        add_vec(ins(OPLD,3'd2,1'b0,1,0,6,32'h100,0,4),    0,1, 32'h0,     32'h0,        4'h0,0,0);
        t = ins(OPR,3'd0,1'b0,6,2,7,0,2,0);
        add_vec(t,                                        1,0, 32'h100,   32'd4,        4'h0,0,1); // load-use stall
        add_vec(t,                                        0,1, 32'h0,     32'h0,        4'h0,0,0); // bubble
        t = idle(); t.wb_we = 1; t.wb_rd = 6; t.wb_dat = 32'h55;
        add_vec(t,                                        1,1, 32'h55,    32'd2,        4'h0,0,1);
        add_vec(ins(OPR,3'd0,1'b0,7,0,8,0,0,0),           0,1, 32'h0,     32'h0,        4'h0,0,0);
        t = idle(); t.out_ready = 0; t.exm_we = 1; t.exm_rd = 7; t.exm_res = 32'h99;
        add_vec(t,                                        1,0, 32'h99,    32'h0,        4'h0,0,1);
        t = idle(); t.out_ready = 0;
        add_vec(t,                                        1,0, 32'h99,    32'h0,        4'h0,0,1); // refreshed
        add_vec(t,                                        1,0, 32'h99,    32'h0,        4'h0,0,1);
        add_vec(idle(),                                   1,1, 32'h99,    32'h0,        4'h0,0,1);
        add_vec(ins(OPLU,3'd0,1'b0,3,0,9,32'h777,0,32'h12345000), 0,1, 32'h0, 32'h0,   4'h0,0,0);
        add_vec(ins(OPBR,3'd0,1'b0,1,2,10,1,2,0),         1,1, 32'h0,     32'h12345000, 4'h3,0,1); // lui
        add_vec(idle(),                                   1,1, 32'd1,     32'd2,        4'hF,1,0); // illegal
        add_vec(ins(OPR,3'd0,1'b0,1,2,11,32'h10,32'h20,0),0,1, 32'h0,     32'h0,        4'h0,0,0);
        t = ins(OPR,3'd0,1'b0,3,0,12,5,0,0); t.out_ready = 0;
        add_vec(t,                                        1,0, 32'h10,    32'h20,       4'h0,0,1);
        t.flush = 1;
        add_vec(t,                                        1,1, 32'h10,    32'h20,       4'h0,0,1); // flush -> ready
        add_vec(idle(),                                   0,1, 32'h0,     32'h0,        4'h0,0,0);
        add_vec(ins(OPR,3'd0,1'b0,1,0,13,32'h44,0,0),     0,1, 32'h0,     32'h0,        4'h0,0,0);
        t = idle(); t.out_ready = 0;
        add_vec(t,                                        1,0, 32'h44,    32'h0,        4'h0,0,1);
        t.rst = 1;
        add_vec(t,                                        1,0, 32'h44,    32'h0,        4'h0,0,1);
        add_vec(idle(),                                   0,1, 32'h0,     32'h0,        4'h0,0,0); // after reset

        drive(idle());
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.s);
            @(negedge clk);
            chk($sformatf("v%0d out_valid", i),     out_valid,     v.ev);
            chk($sformatf("v%0d in_ready", i),      in_ready,      v.er);
            chk($sformatf("v%0d alu_a", i),         alu_a,         v.ea);
            chk($sformatf("v%0d alu_b", i),         alu_b,         v.eb);
            chk($sformatf("v%0d alu_control", i),   alu_control,   v.ec);
            chk($sformatf("v%0d out_illegal", i),   out_illegal,   v.eill);
            chk($sformatf("v%0d out_reg_write", i), out_reg_write, v.erw);
            @(posedge clk);
            #1;
        end

        // ---- randomized traffic against the reference model ----
        m_vld = 0; m_op = 0; m_f3 = 0; m_f7 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            stim_t s;
            kind_e mk, ik;
            logic [31:0] a1, a2, ea, eb, esd;
            logic [3:0]  ec;
            logic [4:0]  erd;
            logic        u1, u2, lu, er, erw, emr, emw, eill;

            s = idle();
            s.in_valid = ($urandom_range(3) != 0);
            case ($urandom_range(6))
                0: s.op = OPR;
                1: s.op = OPI;
                2: s.op = OPLU;
                3: s.op = OPLD;
                4: s.op = OPST;
                default: s.op = 7'($urandom);
            endcase
            case ($urandom_range(2))
                0: s.f3 = 3'd0;
                1: s.f3 = 3'd4;
                default: s.f3 = 3'($urandom);
            endcase
            s.f7  = 1'($urandom_range(1));
            s.rs1 = 5'($urandom_range(7));
            s.rs2 = 5'($urandom_range(7));
            s.rd  = 5'($urandom_range(7));
            s.d1  = $urandom; s.d2 = $urandom; s.imm = $urandom;
            s.exm_we = 1'($urandom_range(1)); s.exm_rd = 5'($urandom_range(7)); s.exm_res = $urandom;
            s.wb_we  = 1'($urandom_range(1)); s.wb_rd  = 5'($urandom_range(7)); s.wb_dat  = $urandom;
            s.out_ready = ($urandom_range(3) != 0);
            s.flush = ($urandom_range(15) == 0);
            s.rst   = ($urandom_range(99) == 0);
            drive(s);
            @(negedge clk);

            mk = kind_of(m_op, m_f3);
            ik = kind_of(s.op, s.f3);
            a1 = fwd(m_rs1, m_d1, s);
            a2 = fwd(m_rs2, m_d2, s);
            u1 = (ik == K_R || ik == K_I || ik == K_LD || ik == K_ST);
            u2 = (ik == K_R || ik == K_ST);
            lu = m_vld && mk == K_LD && m_rd != 0 && s.in_valid &&
                 ((u1 && s.rs1 == m_rd) || (u2 && s.rs2 == m_rd));
            er = s.flush || ((!m_vld || s.out_ready) && !lu);
            if (m_vld) begin
                ea   = (mk == K_LUI) ? 32'h0 : a1;
                eb   = (mk == K_I || mk == K_LUI || mk == K_LD || mk == K_ST) ? m_imm : a2;
                ec   = code_of(mk, m_f3, m_f7);
                erd  = m_rd;
                erw  = (mk == K_R || mk == K_I || mk == K_LUI || mk == K_LD) && m_rd != 0;
                emr  = (mk == K_LD);
                emw  = (mk == K_ST);
                esd  = a2;
                eill = (mk == K_BAD);
            end else begin
                ea = 0; eb = 0; ec = 0; erd = 0; erw = 0; emr = 0; emw = 0; esd = 0; eill = 0;
            end

            chk($sformatf("c%0d out_valid", cyc),      out_valid,      m_vld);
            chk($sformatf("c%0d in_ready", cyc),       in_ready,       er);
            chk($sformatf("c%0d alu_a", cyc),          alu_a,          ea);
            chk($sformatf("c%0d alu_b", cyc),          alu_b,          eb);
            chk($sformatf("c%0d alu_control", cyc),    alu_control,    ec);
            chk($sformatf("c%0d out_rd", cyc),         out_rd,         erd);
            chk($sformatf("c%0d out_reg_write", cyc),  out_reg_write,  erw);
            chk($sformatf("c%0d out_mem_read", cyc),   out_mem_read,   emr);
            chk($sformatf("c%0d out_mem_write", cyc),  out_mem_write,  emw);
            chk($sformatf("c%0d out_store_data", cyc), out_store_data, esd);
            chk($sformatf("c%0d out_illegal", cyc),    out_illegal,    eill);

            @(posedge clk);
            if (s.rst || s.flush) begin
                m_vld = 0;
            end else if (s.in_valid && er) begin
                m_vld = 1; m_op = s.op; m_f3 = s.f3; m_f7 = s.f7;
                m_rs1 = s.rs1; m_rs2 = s.rs2; m_rd = s.rd;
                m_d1 = s.d1; m_d2 = s.d2; m_imm = s.imm;
            end else if (m_vld && s.out_ready) begin
                m_vld = 0;
            end else if (m_vld) begin
                // a stalled instruction keeps whatever values were forwarded to it
                m_d1 = a1;
                m_d2 = a2;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
